ps2_key_tracker: RTL
====================

# ps2_key_tracker

Parametrised successor to the fixed six-key scan-code decoder. It tracks make/break state for N_KEYS configurable PS/2 set-2 scan codes and handles the E0 (extended) and F0 (break) prefixes. It emits one-cycle key events and a tick-sampled key vector that also captures taps shorter than a sample window. It sits between the PS/2 byte receiver and the game/control logic, and runs in the system clock domain.

## Interface
- N_KEYS, 6: number of tracked keys, 1..16.
- KEY_CODES, {8'h1d,8'h23,8'h5a,8'h2d,8'h4b,8'h24}: packed N_KEYS×8 table; bits [8i+7:8i] are the code of key i.
- EXT_MASK, 0: N_KEYS bits; bit i=1 means key i matches only when E0-prefixed, bit i=0 means it matches only when not prefixed.
- TICK_DIV, 1000000: sample period in clk cycles, ≥2.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- code_i  in  8  received scan-code byte; valid only while code_valid_i=1.
- code_valid_i  in  1  one-cycle strobe per received byte.
- keys_held_o  out  N_KEYS  live held state; bit i=1 between make and break of key i.
- keys_o  out  N_KEYS  sampled key vector, updated only on tick.
- tick_o  out  1  one-cycle pulse every TICK_DIV cycles.
- event_valid_o  out  1  one-cycle pulse per matched make/break.
- event_idx_o  out  4  index of the key in the current event.
- event_make_o  out  1  1=make, 0=break; qualified by event_valid_o.
- event_rpt_o  out  1  1=typematic repeat, i.e. a make for a key already held.

## Operation
- Prefix FSM states: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0). The FSM advances only on cycles with code_valid_i=1.
- From IDLE: E0 goes to EXT; F0 goes to BRK; any other byte is a candidate with ext=0, brk=0, and the FSM stays in IDLE.
- From EXT: F0 goes to EXT_BRK; E0 stays in EXT; any other byte is a candidate with ext=1, brk=0, then the FSM returns to IDLE.
- From BRK: F0 stays in BRK; E0 goes to EXT_BRK; any other byte is a candidate with ext=0, brk=1, then the FSM returns to IDLE.
- From EXT_BRK: E0 or F0 stays in EXT_BRK; any other byte is a candidate with ext=1, brk=1, then the FSM returns to IDLE.
- Matching: a candidate matches key i when code_i==KEY_CODES[i] and ext==EXT_MASK[i]. If several keys match, the lowest index wins. A candidate with no match produces no event and no state change.
- Make (brk=0):
  - set held[i] and latch[i];
  - event_make_o=1;
  - event_rpt_o = the previous value of held[i].
- Break (brk=1):
  - clear held[i];
  - event_make_o=0, event_rpt_o=0;
  - a break for a key that is not held still emits an event.
- Tick counter:
  - width $clog2(TICK_DIV); counts 0..TICK_DIV-1 and wraps;
  - tick_o=1 during the cycle the counter equals TICK_DIV-1.
- On a tick cycle:
  - keys_o <= held | latch, using the register values from before this cycle's update;
  - latch is cleared, except a bit being set by a make in the same cycle stays set and counts in the next window.
- Consequence: a key pressed and released inside one window appears in keys_o for exactly one sample.

## Timing
- Event latency: event_valid_o, event_idx_o, event_make_o, event_rpt_o and keys_held_o update on the clock edge after the final byte's code_valid_i. That is one cycle of latency.
- keys_o changes only on the edge ending a tick_o cycle.
- Reset (asynchronous, any time, including mid-prefix): FSM=IDLE, counter=0, held=0, latch=0. All outputs read 0.
- The first tick_o after reset release occurs TICK_DIV-1 edges later.
- Back-to-back code_valid_i on consecutive cycles is supported at full rate. Event outputs are registered and are valid for one cycle only.

## Test plan
- Reset: assert rst_n=0 mid-count. Required: all outputs 0, then tick_o at cycle TICK_DIV-1 after release.
- Make: byte 0x24. Required: next cycle event_valid_o=1, idx=0, make=1, rpt=0, keys_held_o=000001; next tick keys_o=000001.
- Break: 0x4B, then F0 4B. Required: the second event has idx=1, make=0; keys_held_o bit1 returns to 0; repeating 0x4B twice gives rpt=1 on the second event.
- Short tap: 0x2D then F0 2D inside one window. Required: keys_o bit2=1 at the next tick and 0 at the tick after.
- Extended: with defaults, E0 1D gives no event; then 1D gives idx=5. With EXT_MASK bit5=1, the same sequence gives the opposite result.
- Mid-prefix reset: E0 F0, pulse rst_n low, then 0x24. Required: a make event with idx=0 (the prefix is discarded). Also a make coinciding with a tick: keys_o excludes it, the following tick includes it.

Source files
------------

// File: rtl/ps2_key_tracker_if.sv
// Byte-in / event-out handshake between the PS/2 byte receiver, the key tracker
// and the game logic.
interface ps2_key_tracker_if;
  logic [7:0] code_i;
  logic       code_valid_i;
  logic       event_valid_o;
  logic [3:0] event_idx_o;
  logic       event_make_o;
  logic       event_rpt_o;

  modport master (
    output code_i, code_valid_i,
    input  event_valid_o, event_idx_o, event_make_o, event_rpt_o
  );

  modport slave (
    input  code_i, code_valid_i,
    output event_valid_o, event_idx_o, event_make_o, event_rpt_o
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// Tracks make/break state of N_KEYS PS/2 set-2 scan codes, with E0/F0 prefix
// handling, one-cycle key events and a tick-sampled vector that keeps short taps.
//
// state     | meaning
// S_IDLE    | no prefix pending
// S_EXT     | E0 seen
// S_BRK     | F0 seen
// S_EXT_BRK | E0 and F0 seen (either order)
module ps2_key_tracker #(
  parameter int                    N_KEYS    = 6,
  parameter logic [N_KEYS*8-1:0]   KEY_CODES = {8'h1d, 8'h23, 8'h5a, 8'h2d, 8'h4b, 8'h24},
  parameter logic [N_KEYS-1:0]     EXT_MASK  = '0,
  parameter int                    TICK_DIV  = 1000000
) (
  input  logic                clk,
  input  logic                rst_n,
  ps2_key_tracker_if.slave    bus,
  output logic [N_KEYS-1:0]   keys_held_o,
  output logic [N_KEYS-1:0]   keys_o,
  output logic                tick_o
);
  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic [N_KEYS-1:0] r_held;
  logic [N_KEYS-1:0] r_latch;
  logic [N_KEYS-1:0] r_keys;

  state_t            w_next;
  logic              w_cand;
  logic              w_ext;
  logic              w_brk;
  logic              w_hit;
  logic [3:0]        w_idx;
  logic [N_KEYS-1:0] w_mask;
  logic [N_KEYS-1:0] w_set;
  logic [N_KEYS-1:0] w_clr;
  logic              w_tick;

  always_comb begin
    w_next = r_state;
    w_cand = 1'b0;
    w_ext  = (r_state == S_EXT) || (r_state == S_EXT_BRK);
    w_brk  = (r_state == S_BRK) || (r_state == S_EXT_BRK);
    if (bus.code_valid_i) begin
      if (bus.code_i == 8'he0) begin
        w_next = (r_state == S_IDLE || r_state == S_EXT) ? S_EXT : S_EXT_BRK;
      end else if (bus.code_i == 8'hf0) begin
        w_next = (r_state == S_IDLE || r_state == S_BRK) ? S_BRK : S_EXT_BRK;
      end else begin
        w_cand = 1'b1;
        w_next = S_IDLE;
      end
    end
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_idx = 4'd0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[8*i +: 8] == bus.code_i && EXT_MASK[i] == w_ext) begin
        w_hit = 1'b1;
        w_idx = 4'(i);
      end
    end
    w_mask = N_KEYS'(1) << w_idx;
    w_set  = (w_cand && w_hit && !w_brk) ? w_mask : '0;
    w_clr  = (w_cand && w_hit &&  w_brk) ? w_mask : '0;
  end

  assign w_tick = (r_cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_cnt             <= '0;
      r_held            <= '0;
      r_latch           <= '0;
      r_keys            <= '0;
      bus.event_valid_o <= 1'b0;
      bus.event_idx_o   <= 4'd0;
      bus.event_make_o  <= 1'b0;
      bus.event_rpt_o   <= 1'b0;
    end else begin
      r_state           <= w_next;
      r_cnt             <= w_tick ? '0 : r_cnt + 1'b1;
      r_held            <= (r_held & ~w_clr) | w_set;
      bus.event_valid_o <= w_cand && w_hit;
      if (w_cand && w_hit) begin
        bus.event_idx_o  <= w_idx;
        bus.event_make_o <= !w_brk;
        bus.event_rpt_o  <= |(r_held & w_set);
      end
      // A make landing on the tick edge is carried into the next window.
      if (w_tick) begin
        r_keys  <= r_held | r_latch;
        r_latch <= w_set;
      end else begin
        r_latch <= r_latch | w_set;
      end
    end
  end

  assign keys_held_o = r_held;
  assign keys_o      = r_keys;
  assign tick_o      = w_tick;
endmodule
